// File: rtl/axi4l_gpio_pkg.sv
// Shared types, register map and byte-lane helpers for the AXI4-Lite GPIO slave.
package axi4l_gpio_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_t;

   typedef enum logic [1:0] {
      W_IDLE   = 2'd0,
      W_HAVE_A = 2'd1,
      W_HAVE_D = 2'd2,
      W_RESP   = 2'd3
   } wr_state_t;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_RESP = 1'b1
   } rd_state_t;

   // Word index taken from ADDR[4:2]
   localparam logic [2:0] OFF_DATA_OUT = 3'd0;
   localparam logic [2:0] OFF_DIR      = 3'd1;
   localparam logic [2:0] OFF_DATA_IN  = 3'd2;
   localparam logic [2:0] OFF_IRQ_EN   = 3'd3;
   localparam logic [2:0] OFF_IRQ_STAT = 3'd4;

   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{strb[i]}};
      return m;
   endfunction

   function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                                input logic [31:0] wd,
                                                input logic [3:0]  strb);
      logic [31:0] m;
      m = strb_mask(strb);
      return (old & ~m) | (wd & m);
   endfunction

endpackage

// File: rtl/axi4l_gpio_slave_gpio_in_sync.sv
// Two-flop pin synchronizer with a one-cycle rising-edge pulse per bit.
module gpio_in_sync #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pins,
   output logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] rise_c
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync   <= '0;
         prev_q <= '0;
      end else begin
         meta_q <= pins;
         sync   <= meta_q;
         prev_q <= sync;
      end
   end

   assign rise_c = sync & ~prev_q;

endmodule

// File: rtl/axi4l_gpio_slave.sv
// AXI4-Lite subordinate holding the GPIO register file (out, dir, in, irq enable/status).
module axi4l_gpio_slave
   import axi4l_gpio_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned GPIO_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   AWADDR,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [DATA_WIDTH-1:0]   WDATA,
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic                    WVALID,
   output logic                    WREADY,
   output logic [1:0]              BRESP,
   output logic                    BVALID,
   input  logic                    BREADY,
   input  logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]              RRESP,
   output logic                    RVALID,
   input  logic                    RREADY,
   input  logic [GPIO_WIDTH-1:0]   gpio_in,
   output logic [GPIO_WIDTH-1:0]   gpio_out,
   output logic [GPIO_WIDTH-1:0]   gpio_oe,
   output logic                    irq
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   wr_state_t wr_state, wr_next;
   rd_state_t rd_state, rd_next;

   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;

   logic                  wr_commit;
   logic [ADDR_WIDTH-1:0] wr_addr_c;
   logic [DATA_WIDTH-1:0] wr_data_c;
   logic [STRB_WIDTH-1:0] wr_strb_c;
   logic [2:0]            wr_idx;
   logic                  wr_ok;

   logic [2:0]            rd_idx;
   logic                  rd_ok;
   logic [DATA_WIDTH-1:0] rd_val;

   logic [GPIO_WIDTH-1:0] data_out_q, dir_q, irq_en_q, irq_stat_q;
   logic [GPIO_WIDTH-1:0] in_sync, in_rise, stat_clr;

   logic aw_hs, w_hs, ar_hs;
   logic unused_addr_lsbs;

   assign aw_hs = AWVALID & AWREADY;
   assign w_hs  = WVALID & WREADY;
   assign ar_hs = ARVALID & ARREADY;

   gpio_in_sync #(.WIDTH(GPIO_WIDTH)) u_sync (
      .clk    (clk),
      .rst    (rst),
      .pins   (gpio_in),
      .sync   (in_sync),
      .rise_c (in_rise)
   );

   // Write FSM state register
   always_ff @(posedge clk) begin
      if (rst) wr_state <= W_IDLE;
      else     wr_state <= wr_next;
   end

   // Write next state; selects live bus fields or latched halves for the commit
   always_comb begin
      wr_next   = wr_state;
      wr_commit = 1'b0;
      wr_addr_c = awaddr_q;
      wr_data_c = wdata_q;
      wr_strb_c = wstrb_q;
      case (wr_state)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               wr_commit = 1'b1;
               wr_addr_c = AWADDR;
               wr_data_c = WDATA;
               wr_strb_c = WSTRB;
               wr_next   = W_RESP;
            end else if (aw_hs) begin
               wr_next = W_HAVE_A;
            end else if (w_hs) begin
               wr_next = W_HAVE_D;
            end
         end
         W_HAVE_A: begin
            if (w_hs) begin
               wr_commit = 1'b1;
               wr_data_c = WDATA;
               wr_strb_c = WSTRB;
               wr_next   = W_RESP;
            end
         end
         W_HAVE_D: begin
            if (aw_hs) begin
               wr_commit = 1'b1;
               wr_addr_c = AWADDR;
               wr_next   = W_RESP;
            end
         end
         W_RESP: begin
            if (BREADY) wr_next = W_IDLE;
         end
         default: wr_next = W_IDLE;
      endcase
   end

   assign wr_idx = wr_addr_c[4:2];
   assign wr_ok  = (wr_addr_c[ADDR_WIDTH-1:5] == '0) && (wr_idx <= OFF_IRQ_STAT)
                   && (wr_idx != OFF_DATA_IN);

   // Write channel registered outputs and latched halves
   always_ff @(posedge clk) begin
      if (rst) begin
         AWREADY  <= 1'b0;
         WREADY   <= 1'b0;
         BVALID   <= 1'b0;
         BRESP    <= RESP_OKAY;
         awaddr_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
      end else begin
         AWREADY <= (wr_next == W_IDLE) || (wr_next == W_HAVE_D);
         WREADY  <= (wr_next == W_IDLE) || (wr_next == W_HAVE_A);
         BVALID  <= (wr_next == W_RESP);
         if (wr_commit) BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
         if (aw_hs) awaddr_q <= AWADDR;
         if (w_hs) begin
            wdata_q <= WDATA;
            wstrb_q <= WSTRB;
         end
      end
   end

   assign stat_clr = (wr_commit && wr_ok && (wr_idx == OFF_IRQ_STAT))
                     ? GPIO_WIDTH'(wr_data_c & strb_mask(wr_strb_c)) : '0;

   // Register file; a new edge in the same cycle as a W1C keeps the bit set
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out_q <= '0;
         dir_q      <= '0;
         irq_en_q   <= '0;
         irq_stat_q <= '0;
         irq        <= 1'b0;
      end else begin
         if (wr_commit && wr_ok) begin
            case (wr_idx)
               OFF_DATA_OUT: data_out_q <= GPIO_WIDTH'(apply_wstrb(32'(data_out_q), wr_data_c, wr_strb_c));
               OFF_DIR:      dir_q      <= GPIO_WIDTH'(apply_wstrb(32'(dir_q), wr_data_c, wr_strb_c));
               OFF_IRQ_EN:   irq_en_q   <= GPIO_WIDTH'(apply_wstrb(32'(irq_en_q), wr_data_c, wr_strb_c));
               default: ;
            endcase
         end
         irq_stat_q <= (irq_stat_q & ~stat_clr) | in_rise;
         irq        <= |(irq_stat_q & irq_en_q);
      end
   end

   assign gpio_out = data_out_q;
   assign gpio_oe  = dir_q;

   // Read FSM state register
   always_ff @(posedge clk) begin
      if (rst) rd_state <= R_IDLE;
      else     rd_state <= rd_next;
   end

   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         R_IDLE:  if (ar_hs) rd_next = R_RESP;
         R_RESP:  if (RREADY) rd_next = R_IDLE;
         default: rd_next = R_IDLE;
      endcase
   end

   assign rd_idx = ARADDR[4:2];
   assign rd_ok  = (ARADDR[ADDR_WIDTH-1:5] == '0) && (rd_idx <= OFF_IRQ_STAT);

   // Read mux samples pre-write register values
   always_comb begin
      rd_val = '0;
      case (rd_idx)
         OFF_DATA_OUT: rd_val = DATA_WIDTH'(data_out_q);
         OFF_DIR:      rd_val = DATA_WIDTH'(dir_q);
         OFF_DATA_IN:  rd_val = DATA_WIDTH'(in_sync);
         OFF_IRQ_EN:   rd_val = DATA_WIDTH'(irq_en_q);
         OFF_IRQ_STAT: rd_val = DATA_WIDTH'(irq_stat_q);
         default:      rd_val = '0;
      endcase
      if (!rd_ok) rd_val = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ARREADY <= 1'b0;
         RVALID  <= 1'b0;
         RDATA   <= '0;
         RRESP   <= RESP_OKAY;
      end else begin
         ARREADY <= (rd_next == R_IDLE);
         RVALID  <= (rd_next == R_RESP);
         if (ar_hs) begin
            RDATA <= rd_val;
            RRESP <= rd_ok ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   assign unused_addr_lsbs = ^{wr_addr_c[1:0], ARADDR[1:0]};

endmodule

// File: tb/tb_axi4l_gpio_slave.sv
// Scoreboard bench for axi4l_gpio_slave: directed cases followed by random traffic.
module tb_axi4l_gpio_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  AWADDR, ARADDR;
   logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
   logic [1:0]  BRESP, RRESP;
   logic [31:0] RDATA;
   logic [31:0] gpio_in, gpio_out, gpio_oe;
   logic        irq;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } rexp_t;

   logic [1:0] b_exp[$];
   rexp_t      r_exp[$];

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_do, m_dir, m_en, m_stat, m_pins;

   always #5 clk = ~clk;

   axi4l_gpio_slave dut (
      .clk(clk), .rst(rst),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
   );

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   function automatic logic [31:0] bytes_of(input logic [3:0] s);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[i*8 +: 8] = s[i] ? 8'hFF : 8'h00;
      return m;
   endfunction

   // Reference model: register map semantics applied directly
   function automatic logic [1:0] model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] m;
      int idx;
      m   = bytes_of(s);
      idx = int'(a[4:2]);
      if (a[7:5] != 3'd0 || idx > 4 || idx == 2) return 2'b10;
      case (idx)
         0: m_do   = (m_do  & ~m) | (d & m);
         1: m_dir  = (m_dir & ~m) | (d & m);
         3: m_en   = (m_en  & ~m) | (d & m);
         default: m_stat = m_stat & ~(d & m);
      endcase
      return 2'b00;
   endfunction

   function automatic rexp_t model_read(input logic [7:0] a);
      rexp_t e;
      int idx;
      idx = int'(a[4:2]);
      e.resp = 2'b00;
      case (idx)
         0: e.data = m_do;
         1: e.data = m_dir;
         2: e.data = m_pins;
         3: e.data = m_en;
         4: e.data = m_stat;
         default: e.data = 32'h0;
      endcase
      if (a[7:5] != 3'd0 || idx > 4) begin
         e.data = 32'h0;
         e.resp = 2'b10;
      end
      return e;
   endfunction

   // Response monitors: pop expected value on each handshake
   always @(negedge clk) begin
      if (!rst && BVALID && BREADY) begin
         if (b_exp.size() == 0) check32("b_unexpected", 32'(BVALID), 32'd0);
         else check32("bresp", 32'(BRESP), 32'(b_exp.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (!rst && RVALID && RREADY) begin
         if (r_exp.size() == 0) check32("r_unexpected", 32'(RVALID), 32'd0);
         else begin
            rexp_t e;
            e = r_exp.pop_front();
            check32("rdata", RDATA, e.data);
            check32("rresp", 32'(RRESP), 32'(e.resp));
         end
      end
   end

   task automatic wait_aw();
      int t = 0;
      @(negedge clk);
      while (!AWREADY) begin
         if (++t > 50) begin timeout("awready"); break; end
         @(negedge clk);
      end
      @(posedge clk); #1;
      AWVALID = 1'b0;
   endtask

   task automatic wait_w();
      int t = 0;
      @(negedge clk);
      while (!WREADY) begin
         if (++t > 50) begin timeout("wready"); break; end
         @(negedge clk);
      end
      @(posedge clk); #1;
      WVALID = 1'b0;
   endtask

   // Entry and exit: 1 time unit after a rising edge
   task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_stall);
      int t = 0;
      b_exp.push_back(model_write(a, d, s));
      BREADY = 1'b0;
      fork
         begin
            repeat (aw_dly) begin @(posedge clk); #1; end
            AWADDR = a; AWVALID = 1'b1;
            wait_aw();
         end
         begin
            repeat (w_dly) begin @(posedge clk); #1; end
            WDATA = d; WSTRB = s; WVALID = 1'b1;
            wait_w();
         end
      join
      @(negedge clk);
      check32("b_latency", 32'(BVALID), 32'd1);
      repeat (b_stall) begin
         @(posedge clk); @(negedge clk);
         check32("b_held", 32'(BVALID), 32'd1);
      end
      @(posedge clk); #1;
      BREADY = 1'b1;
      @(negedge clk);
      while (!BVALID) begin
         if (++t > 50) begin timeout("bvalid"); break; end
         @(negedge clk);
      end
      @(posedge clk); #1;
      BREADY = 1'b0;
      @(negedge clk);
      check32("b_single", 32'(BVALID), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic do_read(input logic [7:0] a, input int ar_dly, input int r_stall);
      int t = 0;
      r_exp.push_back(model_read(a));
      RREADY = 1'b0;
      repeat (ar_dly) begin @(posedge clk); #1; end
      ARADDR = a; ARVALID = 1'b1;
      @(negedge clk);
      while (!ARREADY) begin
         if (++t > 50) begin timeout("arready"); break; end
         @(negedge clk);
      end
      @(posedge clk); #1;
      ARVALID = 1'b0;
      @(negedge clk);
      check32("r_latency", 32'(RVALID), 32'd1);
      repeat (r_stall) begin @(posedge clk); @(negedge clk); end
      @(posedge clk); #1;
      RREADY = 1'b1;
      t = 0;
      @(negedge clk);
      while (!RVALID) begin
         if (++t > 50) begin timeout("rvalid"); break; end
         @(negedge clk);
      end
      @(posedge clk); #1;
      RREADY = 1'b0;
      @(negedge clk);
      check32("r_single", 32'(RVALID), 32'd0);
      @(posedge clk); #1;
   endtask

   // Pins settle through the synchronizer; any 0->1 bit latches into status
   task automatic set_pins(input logic [31:0] v);
      gpio_in = v;
      m_stat  = m_stat | (v & ~m_pins);
      m_pins  = v;
      repeat (4) begin @(posedge clk); #1; end
   endtask

   task automatic check_outputs(input string tag);
      @(negedge clk);
      check32({tag, "_gpio_out"}, gpio_out, m_do);
      check32({tag, "_gpio_oe"}, gpio_oe, m_dir);
      check32({tag, "_irq"}, 32'(irq), 32'(|(m_stat & m_en)));
      @(posedge clk); #1;
   endtask

   function automatic logic [7:0] rand_addr();
      logic [7:0] a;
      case ($urandom_range(0, 9))
         0, 1, 2, 3, 4: a = {3'b000, 3'($urandom_range(0, 4)), 2'($urandom)};
         5:       a = 8'h14;
         6:       a = 8'h18;
         7:       a = 8'h1C;
         8:       a = {3'($urandom_range(1, 7)), 3'($urandom_range(0, 4)), 2'b00};
         default: a = 8'($urandom);
      endcase
      return a;
   endfunction

   initial begin
      rst = 1'b1;
      AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
      ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0; gpio_in = '0;
      m_do = '0; m_dir = '0; m_en = '0; m_stat = '0; m_pins = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check32("rst_awready", 32'(AWREADY), 32'd0);
      check32("rst_wready",  32'(WREADY),  32'd0);
      check32("rst_arready", 32'(ARREADY), 32'd0);
      check32("rst_bvalid",  32'(BVALID),  32'd0);
      check32("rst_rvalid",  32'(RVALID),  32'd0);
      check32("rst_gpio_out", gpio_out, 32'h0);
      check32("rst_gpio_oe",  gpio_oe,  32'h0);
      check32("rst_irq", 32'(irq), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // Same-cycle AW/W
      do_write(8'h00, 32'hA5A5_0F0F, 4'hF, 0, 0, 0);
      check_outputs("t1");
      // W leads AW by three cycles, response back-pressured
      do_write(8'h04, 32'hFFFF_0000, 4'hF, 3, 0, 4);
      check_outputs("t2");
      // Single byte lane
      do_write(8'h00, 32'h0, 4'hF, 0, 0, 0);
      do_write(8'h00, 32'h0000_3C00, 4'b0010, 0, 1, 0);
      do_read(8'h00, 0, 0);
      // Unmapped read and write to read-only input register
      do_read(8'h14, 0, 0);
      do_write(8'h08, 32'hFFFF_FFFF, 4'hF, 1, 0, 0);
      do_read(8'h08, 0, 0);
      // Interrupt set, clear, and edge colliding with the clear
      do_write(8'h0C, 32'h1, 4'hF, 0, 0, 0);
      set_pins(32'h1);
      check_outputs("t5_set");
      do_read(8'h10, 0, 0);
      do_write(8'h10, 32'h1, 4'hF, 0, 0, 0);
      check_outputs("t5_clr");
      set_pins(32'h0);
      set_pins(32'h1);
      set_pins(32'h0);
      gpio_in = 32'h1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      do_write(8'h10, 32'h1, 4'hF, 0, 0, 0);
      m_stat = m_stat | 32'h1;
      m_pins = 32'h1;
      do_read(8'h10, 0, 0);
      check_outputs("t5_race");

      // Reset while address is held waiting for data
      set_pins(32'h0);
      AWADDR = 8'h00; AWVALID = 1'b1;
      wait_aw();
      rst = 1'b1;
      WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF; WVALID = 1'b1;
      @(posedge clk); #1;
      repeat (3) begin
         @(negedge clk);
         check32("t6_awready", 32'(AWREADY), 32'd0);
         check32("t6_wready",  32'(WREADY),  32'd0);
         check32("t6_bvalid",  32'(BVALID),  32'd0);
         @(posedge clk); #1;
      end
      rst = 1'b0; WVALID = 1'b0;
      m_do = '0; m_dir = '0; m_en = '0; m_stat = '0;
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      check32("t6_bvalid_after", 32'(BVALID), 32'd0);
      @(posedge clk); #1;
      check_outputs("t6");

      // Random traffic against the model
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 5))
            0, 1, 2: do_write(rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 3),
                              $urandom_range(0, 3), $urandom_range(0, 3));
            3, 4:    do_read(rand_addr(), $urandom_range(0, 2), $urandom_range(0, 3));
            default: set_pins($urandom);
         endcase
         check_outputs("rnd");
      end

      check32("b_queue_empty", 32'(b_exp.size()), 32'd0);
      check32("r_queue_empty", 32'(r_exp.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
